// File: rtl/pkt_sentinel_pkg.sv
// Shared types for the IPv4 rule checker: rule entry layout, FSM states and
// the header/rule match predicate.
package pkt_sentinel_pkg;

  localparam int IPV4_W = 32;

  typedef struct packed {
    logic              en;
    logic              allow;
    logic [IPV4_W-1:0] src;
    logic [IPV4_W-1:0] src_mask;
    logic [IPV4_W-1:0] dst;
    logic [IPV4_W-1:0] dst_mask;
  } rule_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } chk_state_e;

  function automatic logic rule_match(input rule_t r,
                                      input logic [IPV4_W-1:0] s,
                                      input logic [IPV4_W-1:0] d);
    return r.en &&
           ((s & r.src_mask) == (r.src & r.src_mask)) &&
           ((d & r.dst_mask) == (r.dst & r.dst_mask));
  endfunction

endpackage

// File: rtl/ip_rule_checker_if.sv
// Header-in / verdict-out bundle between the parser, the rule checker and the
// forward/discard stage.
interface ip_rule_checker_if
  import pkt_sentinel_pkg::*;
#(
  parameter int NUM_RULES = 16
) ();

  localparam int IDX_W = $clog2(NUM_RULES);

  logic              ip_valid;
  logic [IPV4_W-1:0] src_ip;
  logic [IPV4_W-1:0] dst_ip;
  logic              busy;
  logic              decision_valid;
  logic              pkt_allow;
  logic              rule_hit;
  logic [IDX_W-1:0]  hit_idx;

  modport master (
    output ip_valid, src_ip, dst_ip,
    input  busy, decision_valid, pkt_allow, rule_hit, hit_idx
  );

  modport slave (
    input  ip_valid, src_ip, dst_ip,
    output busy, decision_valid, pkt_allow, rule_hit, hit_idx
  );

endinterface

// File: rtl/ip_rule_checker_table.sv
// Rule storage: NUM_RULES registered entries, one synchronous write port and
// one combinational read port.
module ip_rule_table
  import pkt_sentinel_pkg::*;
#(
  parameter int NUM_RULES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [$clog2(NUM_RULES)-1:0] waddr,
  input  rule_t                        wdata,
  input  logic [$clog2(NUM_RULES)-1:0] raddr,
  output rule_t                        rdata
);

  rule_t table_q [NUM_RULES];
  rule_t table_d [NUM_RULES];

  always_comb begin
    for (int i = 0; i < NUM_RULES; i++) begin
      table_d[i] = table_q[i];
    end
    if (we) begin
      table_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_RULES; i++) begin
      if (rst) begin
        table_q[i] <= '0;
      end else begin
        table_q[i] <= table_d[i];
      end
    end
  end

  assign rdata = table_q[raddr];

endmodule

// File: rtl/ip_rule_checker.sv
// First-match IPv4 rule checker: scans the rule table one entry per cycle,
// buffers one pending header and keeps saturating verdict statistics.
module ip_rule_checker
  import pkt_sentinel_pkg::*;
#(
  parameter int   NUM_RULES     = 16,
  parameter logic DEFAULT_ALLOW = 1'b0,
  parameter int   CNT_W         = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  ip_rule_checker_if.slave             hdr,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_RULES)-1:0] cfg_addr,
  input  rule_t                        cfg_rule,
  output logic [CNT_W-1:0]             allow_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic [CNT_W-1:0]             ovf_cnt
);

  localparam int               IDX_W    = $clog2(NUM_RULES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RULES - 1);

  chk_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IPV4_W-1:0] work_src_q, work_src_d;
  logic [IPV4_W-1:0] work_dst_q, work_dst_d;
  logic              pend_valid_q, pend_valid_d;
  logic [IPV4_W-1:0] pend_src_q, pend_src_d;
  logic [IPV4_W-1:0] pend_dst_q, pend_dst_d;
  logic              allow_q, allow_d;
  logic              hit_q, hit_d;
  logic [IDX_W-1:0]  hit_idx_q, hit_idx_d;
  logic [CNT_W-1:0]  allow_cnt_q, allow_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

  rule_t cur_rule;
  logic  cur_match;

  ip_rule_table #(
    .NUM_RULES (NUM_RULES)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_rule),
    .raddr (idx_q),
    .rdata (cur_rule)
  );

  assign cur_match = rule_match(cur_rule, work_src_q, work_dst_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    work_src_d   = work_src_q;
    work_dst_d   = work_dst_q;
    pend_valid_d = pend_valid_q;
    pend_src_d   = pend_src_q;
    pend_dst_d   = pend_dst_q;
    allow_d      = allow_q;
    hit_d        = hit_q;
    hit_idx_d    = hit_idx_q;
    allow_cnt_d  = allow_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    ovf_cnt_d    = ovf_cnt_q;

    case (state_q)
      IDLE: begin
        if (hdr.ip_valid) begin
          work_src_d = hdr.src_ip;
          work_dst_d = hdr.dst_ip;
          idx_d      = '0;
          state_d    = SCAN;
        end
      end

      SCAN: begin
        // The slot only overflows here; in DONE it always drains first.
        if (hdr.ip_valid) begin
          if (!pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_src_d   = hdr.src_ip;
            pend_dst_d   = hdr.dst_ip;
          end else if (!(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + 1'b1;
          end
        end
        if (cur_match) begin
          allow_d   = cur_rule.allow;
          hit_d     = 1'b1;
          hit_idx_d = idx_q;
          state_d   = DONE;
        end else if (idx_q == LAST_IDX) begin
          allow_d   = DEFAULT_ALLOW;
          hit_d     = 1'b0;
          hit_idx_d = '0;
          state_d   = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        if (allow_q) begin
          if (!(&allow_cnt_q)) allow_cnt_d = allow_cnt_q + 1'b1;
        end else begin
          if (!(&drop_cnt_q)) drop_cnt_d = drop_cnt_q + 1'b1;
        end
        if (pend_valid_q) begin
          work_src_d = pend_src_q;
          work_dst_d = pend_dst_q;
          idx_d      = '0;
          state_d    = SCAN;
          if (hdr.ip_valid) begin
            pend_src_d = hdr.src_ip;
            pend_dst_d = hdr.dst_ip;
          end else begin
            pend_valid_d = 1'b0;
          end
        end else if (hdr.ip_valid) begin
          work_src_d = hdr.src_ip;
          work_dst_d = hdr.dst_ip;
          idx_d      = '0;
          state_d    = SCAN;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      work_src_q   <= '0;
      work_dst_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_src_q   <= '0;
      pend_dst_q   <= '0;
      allow_q      <= 1'b0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      allow_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      ovf_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      work_src_q   <= work_src_d;
      work_dst_q   <= work_dst_d;
      pend_valid_q <= pend_valid_d;
      pend_src_q   <= pend_src_d;
      pend_dst_q   <= pend_dst_d;
      allow_q      <= allow_d;
      hit_q        <= hit_d;
      hit_idx_q    <= hit_idx_d;
      allow_cnt_q  <= allow_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      ovf_cnt_q    <= ovf_cnt_d;
    end
  end

  assign hdr.busy           = (state_q != IDLE);
  assign hdr.decision_valid = (state_q == DONE);
  assign hdr.pkt_allow      = allow_q;
  assign hdr.rule_hit       = hit_q;
  assign hdr.hit_idx        = hit_idx_q;
  assign allow_cnt          = allow_cnt_q;
  assign drop_cnt           = drop_cnt_q;
  assign ovf_cnt            = ovf_cnt_q;

endmodule

// File: tb/tb_ip_rule_checker.sv
// Self-checking bench for ip_rule_checker: directed vectors, multi-cycle corner
// sequences and randomized traffic against a first-match reference model.
module tb_ip_rule_checker;
  import pkt_sentinel_pkg::*;

  localparam int NR = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ip_rule_checker_if #(.NUM_RULES(NR)) hdr ();
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  rule_t         cfg_rule;
  logic [31:0]   allow_cnt, drop_cnt, ovf_cnt;

  ip_rule_checker #(
    .NUM_RULES     (NR),
    .DEFAULT_ALLOW (1'b0),
    .CNT_W         (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hdr       (hdr),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_rule  (cfg_rule),
    .allow_cnt (allow_cnt),
    .drop_cnt  (drop_cnt),
    .ovf_cnt   (ovf_cnt)
  );

  // Narrow-counter instance used to reach saturation quickly.
  ip_rule_checker_if #(.NUM_RULES(2)) shdr ();
  logic        s_cfg_we;
  logic [0:0]  s_cfg_addr;
  rule_t       s_cfg_rule;
  logic [2:0]  s_allow_cnt, s_drop_cnt, s_ovf_cnt;

  ip_rule_checker #(
    .NUM_RULES     (2),
    .DEFAULT_ALLOW (1'b0),
    .CNT_W         (3)
  ) sdut (
    .clk       (clk),
    .rst       (rst),
    .hdr       (shdr),
    .cfg_we    (s_cfg_we),
    .cfg_addr  (s_cfg_addr),
    .cfg_rule  (s_cfg_rule),
    .allow_cnt (s_allow_cnt),
    .drop_cnt  (s_drop_cnt),
    .ovf_cnt   (s_ovf_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  rule_t model_tbl [NR];
  int    exp_allow_cnt = 0;
  int    exp_drop_cnt  = 0;
  int    exp_ovf_cnt   = 0;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic        allow;
    logic        hit;
    int          idx;
    int          lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] prefix_mask(input int len);
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    if (len <= 0) return 32'h0;
    return ones << (32 - len);
  endfunction

  // Reference: walk the table from entry 0 and stop at the first enabled entry
  // whose masked fields agree with the header.
  function automatic void model_verdict(input logic [31:0] s, input logic [31:0] d,
                                        output logic a, output logic h, output int k);
    a = 1'b0;
    h = 1'b0;
    k = 0;
    for (int i = 0; i < NR; i++) begin
      if (model_tbl[i].en &&
          (((s ^ model_tbl[i].src) & model_tbl[i].src_mask) == 32'h0) &&
          (((d ^ model_tbl[i].dst) & model_tbl[i].dst_mask) == 32'h0)) begin
        a = model_tbl[i].allow;
        h = 1'b1;
        k = i;
        return;
      end
    end
  endfunction

  task automatic write_rule(input int idx, input rule_t r);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = idx[IW-1:0];
    cfg_rule = r;
    @(negedge clk);
    cfg_we   = 1'b0;
    model_tbl[idx] = r;
  endtask

  task automatic wait_decision(input int t0, output logic a, output logic h,
                               output logic [IW-1:0] k, output int lat, output logic pulse_ok);
    int n;
    n = 0;
    while (!hdr.decision_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    lat = hdr.decision_valid ? (cyc - t0) : -1;
    a   = hdr.pkt_allow;
    h   = hdr.rule_hit;
    k   = hdr.hit_idx;
    @(negedge clk);
    pulse_ok = !hdr.decision_valid;
  endtask

  task automatic apply_stimulus(input logic [31:0] s, input logic [31:0] d,
                                output logic a, output logic h, output logic [IW-1:0] k,
                                output int lat, output logic pulse_ok);
    int t0;
    @(negedge clk);
    hdr.ip_valid = 1'b1;
    hdr.src_ip   = s;
    hdr.dst_ip   = d;
    t0 = cyc;
    @(negedge clk);
    hdr.ip_valid = 1'b0;
    wait_decision(t0, a, h, k, lat, pulse_ok);
  endtask

  task automatic run_and_check(input string name, input logic [31:0] s, input logic [31:0] d,
                               input logic ea, input logic eh, input int ek, input int elat);
    logic          a, h, pulse_ok;
    logic [IW-1:0] k;
    int            lat;
    apply_stimulus(s, d, a, h, k, lat, pulse_ok);
    if (ea) exp_allow_cnt++;
    else    exp_drop_cnt++;
    check_output({name, "_latency"}, lat, elat);
    check_output({name, "_allow"}, a, ea);
    check_output({name, "_hit"}, h, eh);
    check_output({name, "_idx"}, k, ek);
    check_output({name, "_pulse1"}, pulse_ok, 1'b1);
    check_output({name, "_allow_cnt"}, allow_cnt, exp_allow_cnt);
    check_output({name, "_drop_cnt"}, drop_cnt, exp_drop_cnt);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic          a, h, pulse_ok, ra, rh;
    logic [IW-1:0] k;
    int            lat, rk, t0, pulses, p1, p2;
    rule_t         r;
    logic [31:0]   s, d, m;

    rst          = 1'b1;
    hdr.ip_valid = 1'b0;
    hdr.src_ip   = '0;
    hdr.dst_ip   = '0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_rule     = '0;
    shdr.ip_valid = 1'b0;
    shdr.src_ip   = '0;
    shdr.dst_ip   = '0;
    s_cfg_we      = 1'b0;
    s_cfg_addr    = '0;
    s_cfg_rule    = '0;
    for (int i = 0; i < NR; i++) model_tbl[i] = '0;

    vecs[0] = '{32'hC0A80164, 32'hC0A80101, 1'b1, 1'b1, 0, 2};
    vecs[1] = '{32'h0A000005, 32'hC0A80101, 1'b0, 1'b1, 2, 4};
    vecs[2] = '{32'h0A000005, 32'h0A000001, 1'b1, 1'b1, 5, 7};
    vecs[3] = '{32'hC0A80264, 32'hC0A80101, 1'b0, 1'b1, 2, 4};
    vecs[4] = '{32'hC0A801FF, 32'h0A000001, 1'b1, 1'b1, 0, 2};
    vecs[5] = '{32'hC0A800FF, 32'h08080808, 1'b1, 1'b1, 5, 7};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check_output("reset_busy", hdr.busy, 1'b0);
    check_output("reset_decision_valid", hdr.decision_valid, 1'b0);
    check_output("reset_pkt_allow", hdr.pkt_allow, 1'b0);
    check_output("reset_rule_hit", hdr.rule_hit, 1'b0);
    check_output("reset_hit_idx", hdr.hit_idx, 0);
    check_output("reset_allow_cnt", allow_cnt, 0);
    check_output("reset_drop_cnt", drop_cnt, 0);
    check_output("reset_ovf_cnt", ovf_cnt, 0);

    $display("[TB] empty table, default verdict");
    run_and_check("empty_default", 32'hC0A80164, 32'hC0A80101, 1'b0, 1'b0, 0, NR + 1);

    $display("[TB] directed vectors");
    write_rule(0, '{1'b1, 1'b1, 32'hC0A80100, 32'hFFFFFF00, 32'h0, 32'h0});
    write_rule(2, '{1'b1, 1'b0, 32'h0, 32'h0, 32'hC0A80101, 32'hFFFFFFFF});
    write_rule(3, '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0});
    write_rule(5, '{1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0});
    for (int i = 0; i < 6; i++) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].src, vecs[i].dst,
                    vecs[i].allow, vecs[i].hit, vecs[i].idx, vecs[i].lat);
    end

    // Entries are sampled when the scan reaches them: a write behind the scan
    // pointer is missed, one ahead of it is seen.
    $display("[TB] rule writes during a scan");
    write_rule(0, '0);
    write_rule(2, '0);
    write_rule(5, '0);
    @(negedge clk);
    hdr.ip_valid = 1'b1;
    hdr.src_ip   = 32'h01020304;
    hdr.dst_ip   = 32'h05060708;
    t0 = cyc;
    @(negedge clk);
    hdr.ip_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 4'd1;
    cfg_rule = '{1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0};
    model_tbl[1] = cfg_rule;
    @(negedge clk);
    cfg_addr = 4'd10;
    cfg_rule = '{1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    model_tbl[10] = cfg_rule;
    @(negedge clk);
    cfg_we = 1'b0;
    wait_decision(t0, a, h, k, lat, pulse_ok);
    exp_drop_cnt++;
    check_output("midscan_latency", lat, 12);
    check_output("midscan_allow", a, 1'b0);
    check_output("midscan_hit", h, 1'b1);
    check_output("midscan_idx", k, 10);
    check_output("midscan_drop_cnt", drop_cnt, exp_drop_cnt);

    $display("[TB] randomized traffic");
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        r.en       = ($urandom_range(0, 3) != 0);
        r.allow    = $urandom_range(0, 1);
        r.src      = $urandom;
        r.src_mask = prefix_mask($urandom_range(0, 32));
        r.dst      = $urandom;
        r.dst_mask = prefix_mask($urandom_range(0, 32));
        write_rule($urandom_range(0, NR - 1), r);
      end
      if ($urandom_range(0, 1) == 1) begin
        rk = $urandom_range(0, NR - 1);
        m  = model_tbl[rk].src_mask;
        s  = (model_tbl[rk].src & m) | ($urandom & ~m);
        m  = model_tbl[rk].dst_mask;
        d  = (model_tbl[rk].dst & m) | ($urandom & ~m);
      end else begin
        s = $urandom;
        d = $urandom;
      end
      model_verdict(s, d, ra, rh, rk);
      run_and_check($sformatf("rnd%0d", it), s, d, ra, rh, rk, rh ? rk + 2 : NR + 1);
    end

    $display("[TB] reset during a scan with a pending header");
    @(negedge clk);
    hdr.ip_valid = 1'b1;
    hdr.src_ip   = 32'h11111111;
    hdr.dst_ip   = 32'h22222222;
    @(negedge clk);
    hdr.src_ip   = 32'h33333333;
    @(negedge clk);
    hdr.ip_valid = 1'b0;
    repeat (2) @(negedge clk);
    pulses = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NR; i++) model_tbl[i] = '0;
    exp_allow_cnt = 0;
    exp_drop_cnt  = 0;
    exp_ovf_cnt   = 0;
    check_output("rst_busy", hdr.busy, 1'b0);
    check_output("rst_allow_cnt", allow_cnt, 0);
    check_output("rst_drop_cnt", drop_cnt, 0);
    check_output("rst_ovf_cnt", ovf_cnt, 0);
    for (int i = 0; i < 40; i++) begin
      if (hdr.decision_valid) pulses++;
      @(negedge clk);
    end
    check_output("rst_no_decision", pulses, 0);
    run_and_check("post_rst", 32'hC0A80164, 32'h0A000001, 1'b0, 1'b0, 0, NR + 1);

    $display("[TB] three back-to-back headers");
    @(negedge clk);
    hdr.ip_valid = 1'b1;
    hdr.src_ip   = 32'hAAAA0001;
    hdr.dst_ip   = 32'hBBBB0001;
    t0 = cyc;
    @(negedge clk);
    hdr.src_ip   = 32'hAAAA0002;
    @(negedge clk);
    hdr.src_ip   = 32'hAAAA0003;
    @(negedge clk);
    hdr.ip_valid = 1'b0;
    pulses = 0;
    p1 = -1;
    p2 = -1;
    for (int i = 0; i < 60; i++) begin
      if (hdr.decision_valid) begin
        pulses++;
        if (p1 < 0) p1 = cyc - t0;
        else if (p2 < 0) p2 = cyc - t0;
      end
      @(negedge clk);
    end
    exp_drop_cnt += 2;
    exp_ovf_cnt  += 1;
    check_output("burst_pulses", pulses, 2);
    check_output("burst_first_latency", p1, NR + 1);
    check_output("burst_second_latency", p2, 2 * (NR + 1));
    check_output("burst_ovf_cnt", ovf_cnt, exp_ovf_cnt);
    check_output("burst_drop_cnt", drop_cnt, exp_drop_cnt);
    check_output("burst_busy_after", hdr.busy, 1'b0);

    $display("[TB] counter saturation on narrow instance");
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      shdr.ip_valid = 1'b1;
      shdr.src_ip   = $urandom;
      shdr.dst_ip   = $urandom;
      t0 = cyc;
      @(negedge clk);
      shdr.ip_valid = 1'b0;
      lat = 0;
      while (!shdr.decision_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      lat = shdr.decision_valid ? (cyc - t0) : -1;
      @(negedge clk);
      if (i == 0) check_output("sat_latency", lat, 3);
      if (i == 6) check_output("sat_drop_cnt_at_max", s_drop_cnt, 3'd7);
      if (i == 8) check_output("sat_drop_cnt_held", s_drop_cnt, 3'd7);
    end
    check_output("sat_allow_cnt", s_allow_cnt, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
